fe_dispatch_ctrl: RTL and testbench
===================================

# fe_dispatch_ctrl

Front-end dispatch controller: the transmitting end of the dispatch bus into the execution-unit instruction queues. Accepts one renamed batch of up to NUM_PARALLEL_INSTR_DISPATCHES instructions, allocates each valid lane to an execution unit round-robin, and drives the dispatch bus. On per-EU full backpressure it re-drives only the rejected lanes until the whole batch is accepted, then takes the next batch.

## Interface
Parameters:
- NUM_PARALLEL_INSTR_DISPATCHES, 4, dispatch bus lanes
- NUM_EXEC_UNITS, 2**LOG2_NUM_EXEC_UNITS (from pkg_dtypes), EUs on the bus

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- batch_instr_i  in  type_iqueue_entry [N]  renamed batch from rename stage
- batch_instr_valid_i  in  1 [N]  per-lane valid of batch
- batch_valid_i  in  1  batch offered
- batch_ready_o  out  1  batch accepted when batch_valid_i & batch_ready_o
- dispatched_instr_o  out  type_iqueue_entry [N]  dispatch bus data
- dispatched_instr_valid_o  out  1 [N]  dispatch bus lane valid
- dispatched_instr_alloc_euidx_o  out  LOG2_NUM_EXEC_UNITS [N]  target EU per lane
- eu_is_full_i  in  1 [NUM_EXEC_UNITS]  per-EU reject, combinational from EU in same cycle
- dispatch_stall_cycles_o  out  16  stall counter (only with FE_DISPATCH_STALL_CTR_EN)

## Operation
- Held batch register: instr, euidx, pending mask [N]. All dispatch outputs come straight from registers.
- States: IDLE (nothing held), ISSUE (batch fresh, all valid lanes pending), RETRY (subset pending after a reject).
- Capture (batch_valid_i & batch_ready_o): pending = batch_instr_valid_i; lane i euidx = (rr_ptr + count of valid lanes below i) mod NUM_EXEC_UNITS; rr_ptr += popcount(valid) mod NUM_EXEC_UNITS. Invalid lanes: euidx 0, data 0. Batch with zero valid lanes is consumed without entering ISSUE; rr_ptr unchanged.
- dispatched_instr_valid_o[i] = pending[i].
- Reject rule: an EU reporting eu_is_full_i rejects every lane driven to it that cycle; lanes to non-full EUs are accepted.
- Each cycle in ISSUE/RETRY: pending_next[i] = pending[i] & eu_is_full_i[euidx[i]].
- all_accepted = pending_next == 0. batch_ready_o = (state==IDLE) | all_accepted (combinational on eu_is_full_i; allows back-to-back batches).
- Transitions: IDLE->ISSUE on capture of non-empty batch. ISSUE/RETRY->ISSUE on all_accepted with new capture; ->IDLE on all_accepted without capture; ->RETRY otherwise. euidx never reallocated on retry.
- A lane is never driven after acceptance (no duplicates into EU queues).

## Timing
- Reset (async assert): state IDLE, rr_ptr 0, pending 0, all dispatch outputs 0, batch_ready_o 1, stall counter 0. Reset mid-batch discards held batch.
- Latency: batch captured at edge E appears on the bus in the cycle after E.
- Throughput: one batch per cycle with no backpressure.
- Rejected lanes re-driven the following cycle, same data/euidx.
- Simultaneous full on all targeted EUs: pending unchanged, state RETRY, held indefinitely (no timeout).
- eu_is_full_i for EUs not targeted by any pending lane is ignored.
- rr_ptr wraps modulo NUM_EXEC_UNITS; lane euidx arithmetic in LOG2_NUM_EXEC_UNITS bits, natural wrap.

## Configuration
- FE_DISPATCH_STALL_CTR_EN defined: dispatch_stall_cycles_o counts cycles in which state is ISSUE/RETRY and all_accepted is 0; saturates at 16'hFFFF; cleared only by reset.
- Undefined: port absent, no counter logic.

## Test plan
- Reset, then batch valid lanes 1111, no full -> next cycle bus valid 1111, euidx 0,1,2,3 (4 EUs), batch_ready_o 1 throughout, rr_ptr 0.
- Batch lanes 1010 then batch 1111 back-to-back -> first euidx lane1=0, lane3=1; second euidx 2,3,0,1.
- Batch 1111, eu_is_full_i[2]=1 for one cycle -> next cycle only lane 2 valid, euidx 2, state RETRY, batch_ready_o 0 in the reject cycle; lane 2 accepted -> IDLE.
- EU1 full for 5 cycles with lane targeting EU1 -> lane re-driven 6 cycles, other lanes driven once; stall counter 5 with FE_DISPATCH_STALL_CTR_EN.
- Batch with valid lanes 0000 -> bus stays invalid, rr_ptr unchanged, batch_ready_o 1.
- reset_n low during RETRY -> outputs 0 immediately (async), IDLE after release, held batch gone.

Source files
------------

// File: rtl/fe_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fe_dispatch_ctrl (with pkg_dtypes)
// Brief    : Front-end dispatch controller. Allocates batch lanes to EUs
//            round-robin and re-drives rejected lanes until fully accepted.
//            Optional stall counter: define FE_DISPATCH_STALL_CTR_EN.
// Revision : 1.0 - initial release
// ============================================================================

package pkg_dtypes;
    localparam int LOG2_NUM_EXEC_UNITS = 2;
    typedef logic [31:0] type_iqueue_entry;
endpackage

module fe_dispatch_ctrl
    import pkg_dtypes::*;
#(
    parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
    parameter int NUM_EXEC_UNITS                = 2**LOG2_NUM_EXEC_UNITS
) (
    input  logic                                                    clk,
    input  logic                                                    reset_n,
    input  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]    batch_instr_i,
    input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                batch_instr_valid_i,
    input  logic                                                    batch_valid_i,
    output logic                                                    batch_ready_o,
    output type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]    dispatched_instr_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                dispatched_instr_valid_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][LOG2_NUM_EXEC_UNITS-1:0] dispatched_instr_alloc_euidx_o,
    input  logic [NUM_EXEC_UNITS-1:0]                               eu_is_full_i
`ifdef FE_DISPATCH_STALL_CTR_EN
    ,output logic [15:0]                                            dispatch_stall_cycles_o
`endif
);

    localparam int N  = NUM_PARALLEL_INSTR_DISPATCHES;
    localparam int EW = LOG2_NUM_EXEC_UNITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RETRY = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [EW-1:0]                rr_ptr_q, rr_ptr_d;
    type_iqueue_entry [N-1:0]     instr_q, instr_d;
    logic [N-1:0][EW-1:0]         euidx_q, euidx_d;
    logic [N-1:0]                 pending_q, pending_d;

    logic [N-1:0]                 pending_next;
    logic                         all_accepted;
    logic                         capture;
    type_iqueue_entry [N-1:0]     alloc_instr;
    logic [N-1:0][EW-1:0]         alloc_euidx;
    logic [EW-1:0]                alloc_run;

    // A lane stays pending only while the EU it targets reports full.
    always_comb begin
        pending_next = '0;
        for (int i = 0; i < N; i++) begin
            pending_next[i] = pending_q[i] & eu_is_full_i[euidx_q[i]];
        end
    end

    assign all_accepted  = ~|pending_next;
    assign batch_ready_o = (state_q == ST_IDLE) | all_accepted;
    assign capture       = batch_valid_i & batch_ready_o;

    // Valid lanes take consecutive EUs starting at rr_ptr; the running count
    // wraps naturally in EW bits, which is the modulo on the EU count.
    always_comb begin
        alloc_run   = '0;
        alloc_instr = '0;
        alloc_euidx = '0;
        for (int i = 0; i < N; i++) begin
            if (batch_instr_valid_i[i]) begin
                alloc_euidx[i] = rr_ptr_q + alloc_run;
                alloc_instr[i] = batch_instr_i[i];
                alloc_run      = alloc_run + EW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        instr_d   = instr_q;
        euidx_d   = euidx_q;
        pending_d = pending_q;
        if (capture) begin
            pending_d = batch_instr_valid_i;
            instr_d   = alloc_instr;
            euidx_d   = alloc_euidx;
            rr_ptr_d  = rr_ptr_q + alloc_run;
            state_d   = (|batch_instr_valid_i) ? ST_ISSUE : ST_IDLE;
        end else if (state_q != ST_IDLE) begin
            pending_d = pending_next;
            state_d   = all_accepted ? ST_IDLE : ST_RETRY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            instr_q   <= '0;
            euidx_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            instr_q   <= instr_d;
            euidx_q   <= euidx_d;
            pending_q <= pending_d;
        end
    end

    assign dispatched_instr_o             = instr_q;
    assign dispatched_instr_valid_o       = pending_q;
    assign dispatched_instr_alloc_euidx_o = euidx_q;

`ifdef FE_DISPATCH_STALL_CTR_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != ST_IDLE) && !all_accepted && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dispatch_stall_cycles_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fe_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fe_dispatch_ctrl
// Brief    : Directed self-checking bench for fe_dispatch_ctrl (4 lanes, 4 EUs).
// Revision : 1.0 - initial release
// ============================================================================

module tb_fe_dispatch_ctrl;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [3:0][31:0]  batch_instr;
    logic [3:0]        batch_instr_valid;
    logic              batch_valid;
    logic              batch_ready;
    logic [3:0][31:0]  disp_instr;
    logic [3:0]        disp_valid;
    logic [3:0][1:0]   disp_euidx;
    logic [3:0]        eu_full;
`ifdef FE_DISPATCH_STALL_CTR_EN
    logic [15:0]       stall_cycles;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fe_dispatch_ctrl #(
        .NUM_PARALLEL_INSTR_DISPATCHES (4),
        .NUM_EXEC_UNITS                (4)
    ) u_dut (
        .clk                            (clk),
        .reset_n                        (reset_n),
        .batch_instr_i                  (batch_instr),
        .batch_instr_valid_i            (batch_instr_valid),
        .batch_valid_i                  (batch_valid),
        .batch_ready_o                  (batch_ready),
        .dispatched_instr_o             (disp_instr),
        .dispatched_instr_valid_o       (disp_valid),
        .dispatched_instr_alloc_euidx_o (disp_euidx),
        .eu_is_full_i                   (eu_full)
`ifdef FE_DISPATCH_STALL_CTR_EN
        ,.dispatch_stall_cycles_o       (stall_cycles)
`endif
    );

    // Expected bus data: valid lanes carry base+lane, invalid lanes are zero.
    function automatic logic [127:0] exp_data(input logic [3:0] v, input logic [31:0] base);
        logic [3:0][31:0] d;
        for (int i = 0; i < 4; i++) d[i] = v[i] ? base + 32'(i) : 32'd0;
        return d;
    endfunction

    task automatic set_batch(input logic [3:0] v, input logic [31:0] base);
        batch_valid       = 1'b1;
        batch_instr_valid = v;
        for (int i = 0; i < 4; i++) batch_instr[i] = base + 32'(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        batch_valid       = 1'b0;
        batch_instr_valid = '0;
        batch_instr       = '0;
        eu_full           = '0;
        reset_n           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        batch_valid = 1'b0; batch_instr_valid = '0; batch_instr = '0; eu_full = '0;
        reset_n = 1'b0;
        #3;
        vectors++;
        if (disp_valid !== 4'h0) begin miscompares++; $display("FAIL reset_valid: got %b want 0000", disp_valid); end
        vectors++;
        if (disp_euidx !== 8'h00) begin miscompares++; $display("FAIL reset_euidx: got %h want 00", disp_euidx); end
        vectors++;
        if (disp_instr !== 128'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", disp_instr); end
        vectors++;
        if (batch_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", batch_ready); end
`ifdef FE_DISPATCH_STALL_CTR_EN
        vectors++;
        if (stall_cycles !== 16'd0) begin miscompares++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_full_batch();
        apply_reset();
        set_batch(4'b1111, 32'h100);
        #1;
        vectors++;
        if (batch_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_idle: got %b want 1", batch_ready); end
        step();
        batch_valid = 1'b0;
        vectors++;
        if (disp_valid !== 4'b1111) begin miscompares++; $display("FAIL full_valid: got %b want 1111", disp_valid); end
        vectors++;
        if (disp_euidx !== 8'he4) begin miscompares++; $display("FAIL full_euidx: got %h want e4", disp_euidx); end
        vectors++;
        if (disp_instr !== exp_data(4'b1111, 32'h100)) begin miscompares++; $display("FAIL full_data: got %h want %h", disp_instr, exp_data(4'b1111, 32'h100)); end
        #1;
        vectors++;
        if (batch_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_busy: got %b want 1", batch_ready); end
        step();
        vectors++;
        if (disp_valid !== 4'b0000) begin miscompares++; $display("FAIL full_drain: got %b want 0000", disp_valid); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_batch(4'b1010, 32'h200);
        step();
        set_batch(4'b1111, 32'h300);
        #1;
        vectors++;
        if (batch_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b want 1", batch_ready); end
        vectors++;
        if (disp_valid !== 4'b1010) begin miscompares++; $display("FAIL b2b_first_valid: got %b want 1010", disp_valid); end
        vectors++;
        if (disp_euidx !== 8'h40) begin miscompares++; $display("FAIL b2b_first_euidx: got %h want 40", disp_euidx); end
        vectors++;
        if (disp_instr !== exp_data(4'b1010, 32'h200)) begin miscompares++; $display("FAIL b2b_first_data: got %h want %h", disp_instr, exp_data(4'b1010, 32'h200)); end
        step();
        batch_valid = 1'b0;
        vectors++;
        if (disp_valid !== 4'b1111) begin miscompares++; $display("FAIL b2b_second_valid: got %b want 1111", disp_valid); end
        vectors++;
        if (disp_euidx !== 8'h4e) begin miscompares++; $display("FAIL b2b_second_euidx: got %h want 4e", disp_euidx); end
        vectors++;
        if (disp_instr !== exp_data(4'b1111, 32'h300)) begin miscompares++; $display("FAIL b2b_second_data: got %h want %h", disp_instr, exp_data(4'b1111, 32'h300)); end
        step();
        vectors++;
        if (disp_valid !== 4'b0000) begin miscompares++; $display("FAIL b2b_drain: got %b want 0000", disp_valid); end
    endtask

    task automatic test_reject();
        apply_reset();
        set_batch(4'b1111, 32'h400);
        step();
        // A new batch offered during the reject cycle must wait.
        set_batch(4'b0001, 32'h500);
        eu_full = 4'b0100;
        #1;
        vectors++;
        if (batch_ready !== 1'b0) begin miscompares++; $display("FAIL rej_ready: got %b want 0", batch_ready); end
        step();
        eu_full = 4'b0000;
        #1;
        vectors++;
        if (disp_valid !== 4'b0100) begin miscompares++; $display("FAIL rej_retry_valid: got %b want 0100", disp_valid); end
        vectors++;
        if (disp_euidx[2] !== 2'd2) begin miscompares++; $display("FAIL rej_retry_euidx: got %0d want 2", disp_euidx[2]); end
        vectors++;
        if (disp_instr[2] !== 32'h402) begin miscompares++; $display("FAIL rej_retry_data: got %h want 402", disp_instr[2]); end
        vectors++;
        if (batch_ready !== 1'b1) begin miscompares++; $display("FAIL rej_retry_ready: got %b want 1", batch_ready); end
        step();
        batch_valid = 1'b0;
        vectors++;
        if (disp_valid !== 4'b0001) begin miscompares++; $display("FAIL rej_next_valid: got %b want 0001", disp_valid); end
        vectors++;
        if (disp_euidx !== 8'h00) begin miscompares++; $display("FAIL rej_next_euidx: got %h want 00", disp_euidx); end
        vectors++;
        if (disp_instr !== exp_data(4'b0001, 32'h500)) begin miscompares++; $display("FAIL rej_next_data: got %h want %h", disp_instr, exp_data(4'b0001, 32'h500)); end
    endtask

    task automatic test_stall();
        int lane0_cnt;
        int lane1_cnt;
        lane0_cnt = 0;
        lane1_cnt = 0;
        apply_reset();
        set_batch(4'b1111, 32'h600);
        step();
        batch_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (disp_valid[0]) lane0_cnt++;
            if (disp_valid[1]) lane1_cnt++;
            eu_full = (c < 5) ? 4'b0010 : 4'b0000;
            step();
        end
        vectors++;
        if (lane1_cnt !== 6) begin miscompares++; $display("FAIL stall_lane1_drives: got %0d want 6", lane1_cnt); end
        vectors++;
        if (lane0_cnt !== 1) begin miscompares++; $display("FAIL stall_lane0_drives: got %0d want 1", lane0_cnt); end
        vectors++;
        if (disp_valid !== 4'b0000) begin miscompares++; $display("FAIL stall_drain: got %b want 0000", disp_valid); end
`ifdef FE_DISPATCH_STALL_CTR_EN
        vectors++;
        if (stall_cycles !== 16'd5) begin miscompares++; $display("FAIL stall_counter: got %0d want 5", stall_cycles); end
`endif
    endtask

    task automatic test_empty();
        apply_reset();
        set_batch(4'b0001, 32'h700);
        step();
        set_batch(4'b0000, 32'h800);
        #1;
        vectors++;
        if (batch_ready !== 1'b1) begin miscompares++; $display("FAIL empty_ready_offer: got %b want 1", batch_ready); end
        step();
        set_batch(4'b1111, 32'h900);
        vectors++;
        if (disp_valid !== 4'b0000) begin miscompares++; $display("FAIL empty_bus: got %b want 0000", disp_valid); end
        #1;
        vectors++;
        if (batch_ready !== 1'b1) begin miscompares++; $display("FAIL empty_ready_after: got %b want 1", batch_ready); end
        step();
        batch_valid = 1'b0;
        vectors++;
        if (disp_euidx !== 8'h39) begin miscompares++; $display("FAIL empty_rr_kept: got %h want 39", disp_euidx); end
        vectors++;
        if (disp_valid !== 4'b1111) begin miscompares++; $display("FAIL empty_next_valid: got %b want 1111", disp_valid); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_batch(4'b1111, 32'ha00);
        step();
        batch_valid = 1'b0;
        eu_full = 4'b1111;
        step();
        vectors++;
        if (disp_valid !== 4'b1111) begin miscompares++; $display("FAIL arst_hold: got %b want 1111", disp_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (disp_valid !== 4'b0000) begin miscompares++; $display("FAIL arst_valid: got %b want 0000", disp_valid); end
        vectors++;
        if (disp_instr !== 128'h0) begin miscompares++; $display("FAIL arst_data: got %h want 0", disp_instr); end
        vectors++;
        if (disp_euidx !== 8'h00) begin miscompares++; $display("FAIL arst_euidx: got %h want 00", disp_euidx); end
        vectors++;
        if (batch_ready !== 1'b1) begin miscompares++; $display("FAIL arst_ready: got %b want 1", batch_ready); end
`ifdef FE_DISPATCH_STALL_CTR_EN
        vectors++;
        if (stall_cycles !== 16'd0) begin miscompares++; $display("FAIL arst_stall: got %0d want 0", stall_cycles); end
`endif
        eu_full = 4'b0000;
        step();
        reset_n = 1'b1;
        step();
        vectors++;
        if (disp_valid !== 4'b0000) begin miscompares++; $display("FAIL arst_gone: got %b want 0000", disp_valid); end
        set_batch(4'b0011, 32'hb00);
        step();
        batch_valid = 1'b0;
        vectors++;
        if (disp_valid !== 4'b0011) begin miscompares++; $display("FAIL arst_new_valid: got %b want 0011", disp_valid); end
        vectors++;
        if (disp_euidx !== 8'h04) begin miscompares++; $display("FAIL arst_new_euidx: got %h want 04", disp_euidx); end
    endtask

    initial begin
        test_reset();
        test_full_batch();
        test_back_to_back();
        test_reject();
        test_stall();
        test_empty();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
